// File: rtl/udp_tx_arbiter.sv
// -----------------------------------------------------------------------------
// udp_tx_arbiter
// Shares the single UDP transmit port of the network block among NREQ frame
// sources in the tx_clock domain. Source 0 (discovery) has strict priority;
// sources 1..NREQ-1 are served round-robin. One frame is sequenced at a time:
// IDLE -> REQ -> XFER -> GAP -> IDLE. GAP is skipped when GAP == 0. A watchdog
// abandons a frame the network never starts.
//
// Ports
//   tx_clock, rst_n   clock (rising edge) and asynchronous active-low reset
//   tx_inhibit        1 = only source 0 may be granted
//   src_req           level request per source, held until its src_done
//   src_len           11-bit payload length per source, slice i = [11*i +: 11]
//   src_data          byte per source, slice i = [8*i +: 8]
//   src_grant         one-hot grant, held from grant until frame end
//   src_rdreq         byte pop strobe to the granted source (combinational)
//   src_done          1-cycle pulse when a frame is sent or abandoned
//   udp_tx_request    frame request to the network
//   udp_tx_length     latched length of the requested frame
//   udp_tx_data       byte to the network (combinational)
//   udp_tx_enable     network consumes a byte this cycle
//   udp_tx_active     network is transmitting the frame
//   timeout_err       sticky watchdog expiry flag
//   overrun_err       sticky flag: network asked for more bytes than latched
// -----------------------------------------------------------------------------
module udp_tx_arbiter #(
  parameter int NREQ    = 3,
  parameter int GAP     = 12,
  parameter int TIMEOUT = 4095
) (
  input  logic                 tx_clock,
  input  logic                 rst_n,
  input  logic                 tx_inhibit,
  input  logic [NREQ-1:0]      src_req,
  input  logic [NREQ*11-1:0]   src_len,
  input  logic [NREQ*8-1:0]    src_data,
  output logic [NREQ-1:0]      src_grant,
  output logic [NREQ-1:0]      src_rdreq,
  output logic [NREQ-1:0]      src_done,
  output logic                 udp_tx_request,
  output logic [10:0]          udp_tx_length,
  output logic [7:0]           udp_tx_data,
  input  logic                 udp_tx_enable,
  input  logic                 udp_tx_active,
  output logic                 timeout_err,
  output logic                 overrun_err
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = 16;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_GAP} state_t;

  // Where a finished or abandoned frame goes next.
  localparam state_t POST_FRAME = (GAP == 0) ? S_IDLE : S_GAP;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [10:0]     len_q, len_d;
  logic [10:0]     byte_cnt_q, byte_cnt_d;
  logic [11:0]     wait_cnt_q, wait_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            req_q, req_d;
  logic            active_q, active_d;
  logic            terr_q, terr_d;
  logic            oerr_q, oerr_d;

  logic [NREQ-1:0] eligible;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [10:0]     pick_len;
  logic [7:0]      cur_byte;
  logic            in_frame;

  // Arbitration: source 0 first, otherwise scan 1..NREQ-1 starting at rr_q.
  always_comb begin
    eligible = tx_inhibit ? (src_req & NREQ'(1)) : src_req;
    pick_vld = 1'b0;
    pick_idx = '0;
    if (eligible[0]) begin
      pick_vld = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        if (!pick_vld && eligible[1 + (int'(rr_q) - 1 + k) % (NREQ - 1)]) begin
          pick_vld = 1'b1;
          pick_idx = IW'(1 + (int'(rr_q) - 1 + k) % (NREQ - 1));
        end
      end
    end
    pick_len = '0;
    cur_byte = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (pick_idx == IW'(k)) pick_len = src_len[11*k +: 11];
      if (gidx_q == IW'(k))   cur_byte = src_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = '0;
    gidx_d     = gidx_q;
    rr_d       = rr_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    wait_cnt_d = wait_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    req_d      = req_q;
    active_d   = udp_tx_active;
    terr_d     = terr_q;
    oerr_d     = oerr_q;
    src_rdreq  = '0;
    udp_tx_data = 8'h00;
    in_frame   = (byte_cnt_q < len_q);

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = NREQ'(1) << pick_idx;
          gidx_d     = pick_idx;
          len_d      = pick_len;
          byte_cnt_d = '0;
          wait_cnt_d = '0;
          req_d      = 1'b1;
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (udp_tx_active) begin
          req_d   = 1'b0;
          state_d = S_XFER;
        end else if (wait_cnt_q == 12'(TIMEOUT - 1)) begin
          // Network never started the frame: release the source.
          terr_d    = 1'b1;
          done_d    = grant_q;
          grant_d   = '0;
          req_d     = 1'b0;
          gap_cnt_d = '0;
          state_d   = POST_FRAME;
        end else begin
          wait_cnt_d = wait_cnt_q + 12'd1;
        end
      end
      S_XFER: begin
        if (in_frame) udp_tx_data = cur_byte;
        if (udp_tx_enable) begin
          if (in_frame) begin
            src_rdreq  = grant_q;
            byte_cnt_d = byte_cnt_q + 11'd1;
          end else begin
            oerr_d = 1'b1;
          end
        end
        // Frame end is the falling edge of udp_tx_active.
        if (active_q && !udp_tx_active) begin
          done_d    = grant_q;
          grant_d   = '0;
          gap_cnt_d = '0;
          state_d   = POST_FRAME;
          if (gidx_q != '0) begin
            rr_d = (gidx_q == IW'(NREQ - 1)) ? IW'(1) : gidx_q + IW'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) state_d = S_IDLE;
        else                           gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge tx_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      done_q     <= '0;
      gidx_q     <= '0;
      rr_q       <= IW'(1);
      len_q      <= '0;
      byte_cnt_q <= '0;
      wait_cnt_q <= '0;
      gap_cnt_q  <= '0;
      req_q      <= 1'b0;
      active_q   <= 1'b0;
      terr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      gidx_q     <= gidx_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      req_q      <= req_d;
      active_q   <= active_d;
      terr_q     <= terr_d;
      oerr_q     <= oerr_d;
    end
  end

  assign src_grant      = grant_q;
  assign src_done       = done_q;
  assign udp_tx_request = req_q;
  assign udp_tx_length  = len_q;
  assign timeout_err    = terr_q;
  assign overrun_err    = oerr_q;

endmodule
